// File: rtl/frame_wr_pkg.sv
// frame_wr_pkg: shared FSM encoding and derived sizing for the frame writer
package frame_wr_pkg;
  typedef enum logic [1:0] {IDLE, ARM, CAPT, DONE} state_t;
  localparam int PPW = 128 / 8;
  localparam int FRAME_WORDS = 2048 * 2048 / PPW;
  function automatic int ppw_of(input int data_w, input int pix_w);
    return data_w / pix_w;
  endfunction
  function automatic int frame_words_of(input int line_pix, input int lines, input int ppw);
    return line_pix * lines / ppw;
  endfunction
endpackage

// File: rtl/frame_word_fifo.sv
// frame_word_fifo: synchronous first-word-fall-through FIFO with level output
module frame_word_fifo #(
  parameter int W = 128,
  parameter int D = 128,
  localparam int AW = D > 1 ? $clog2(D) : 1,
  localparam int LW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] lvl_q;
  logic wr, rd;
  assign full  = lvl_q == LW'(D);
  assign empty = lvl_q == '0;
  assign level = lvl_q;
  assign dout  = mem[rp_q];
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  // pointer and level bookkeeping; a pop frees the slot a same-cycle push uses
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q == AW'(D - 1) ? '0 : wp_q + 1'b1;
      if (rd) rp_q <= rp_q == AW'(D - 1) ? '0 : rp_q + 1'b1;
      lvl_q <= lvl_q + LW'(wr) - LW'(rd);
    end
  end
  // storage array, contents need no reset
  always_ff @(posedge clk) begin
    if (wr) mem[wp_q] <= din;
  end
endmodule

// File: rtl/ddr3_frame_writer.sv
// ddr3_frame_writer: captures one pixel frame, packs words and bursts them into ping-pong DDR3 banks
module ddr3_frame_writer import frame_wr_pkg::*; #(
  parameter int PIX_W       = 8,
  parameter int DATA_W      = 128,
  parameter int LINE_PIX    = 2048,
  parameter int FRAME_LINES = 2048,
  parameter int BURST_WORDS = 64,
  parameter int ADDR_W      = 28,
  parameter int BANK0_BASE  = 0,
  parameter int BANK1_BASE  = 2**24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_start,
  input  logic              pix_sof,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic              wr_data_valid,
  input  logic              wr_data_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic              write_frame_done,
  output logic              wr_bank,
  output logic              busy,
  output logic              overflow
);
  localparam int PW    = ppw_of(DATA_W, PIX_W);
  localparam int FW    = frame_words_of(LINE_PIX, FRAME_LINES, PW);
  localparam int FP    = LINE_PIX * FRAME_LINES;
  localparam int DEPTH = 2 * BURST_WORDS;
  localparam int PCW   = $clog2(FP + 1);
  localparam int SW    = PW > 1 ? $clog2(PW) : 1;
  localparam int TW    = $clog2(FW + 1);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int BW    = BURST_WORDS > 1 ? $clog2(BURST_WORDS) : 1;
  state_t state_q;
  logic [PCW-1:0] pix_cnt_q;
  logic [SW-1:0] slot_q;
  logic [DATA_W-1:0] pack_q, pack_d, head;
  logic [TW-1:0] total_q;
  logic [BW-1:0] beat_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LW-1:0] level;
  logic cmd_q, open_q, bank_q, done_q, wr_bank_q, busy_q, ovf_q;
  logic cap_done, take, push, pop, full, empty, drop, last_word, issue;
  frame_word_fifo #(.W(DATA_W), .D(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(pack_d), .pop(pop),
    .dout(head), .full(full), .empty(empty), .level(level)
  );
  assign wr_cmd_valid     = cmd_q;
  assign wr_cmd_addr      = addr_q;
  assign wr_data_valid    = open_q && !empty;
  assign wr_data          = wr_data_valid ? head : '0;
  assign write_frame_done = done_q;
  assign wr_bank          = wr_bank_q;
  assign busy             = busy_q;
  assign overflow         = ovf_q;
  // pixel acceptance, word packing and burst/termination decisions; dropped words still count toward the frame
  always_comb begin
    cap_done  = pix_cnt_q == PCW'(FP);
    take      = pix_valid && ((state_q == ARM && pix_sof) || (state_q == CAPT && !cap_done));
    push      = take && slot_q == SW'(PW - 1);
    pop       = wr_data_valid && wr_data_ready;
    drop      = push && full && !pop;
    last_word = state_q == CAPT && total_q + TW'(pop) + TW'(drop) == TW'(FW);
    issue     = state_q == CAPT && !cmd_q && !open_q && (level >= LW'(BURST_WORDS) || (cap_done && level != '0));
    pack_d    = pack_q;
    pack_d[slot_q*PIX_W +: PIX_W] = pix_data;
  end
  // frame FSM with command/data phase tracking and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      slot_q    <= '0;
      pack_q    <= '0;
      total_q   <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
      cmd_q     <= 1'b0;
      open_q    <= 1'b0;
      bank_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_bank_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (take) begin
        pack_q    <= pack_d;
        slot_q    <= push ? '0 : slot_q + 1'b1;
        pix_cnt_q <= pix_cnt_q + 1'b1;
      end
      if (drop) ovf_q <= 1'b1;
      if (issue) cmd_q <= 1'b1;
      if (cmd_q && wr_cmd_ready) begin
        cmd_q  <= 1'b0;
        open_q <= 1'b1;
        beat_q <= '0;
      end
      if (pop) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == BW'(BURST_WORDS - 1)) begin
          open_q <= 1'b0;
          addr_q <= addr_q + ADDR_W'(BURST_WORDS);
        end
      end
      if (state_q == CAPT) total_q <= total_q + TW'(pop) + TW'(drop);
      if (state_q == IDLE && write_start) begin
        state_q   <= ARM;
        busy_q    <= 1'b1;
        ovf_q     <= 1'b0;
        pix_cnt_q <= '0;
        slot_q    <= '0;
        total_q   <= '0;
        addr_q    <= bank_q ? ADDR_W'(BANK1_BASE) : ADDR_W'(BANK0_BASE);
      end
      if (state_q == ARM && take) state_q <= CAPT;
      if (last_word) begin
        state_q   <= DONE;
        done_q    <= 1'b1;
        wr_bank_q <= bank_q;
        bank_q    <= ~bank_q;
        busy_q    <= 1'b0;
        open_q    <= 1'b0;
        cmd_q     <= 1'b0;
      end
      if (state_q == DONE) state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_ddr3_frame_writer.sv
// tb_ddr3_frame_writer: scoreboard bench for the frame writer
module tb_ddr3_frame_writer;
  localparam int B1 = 2**24;
  logic clk = 0, rst = 1, ws = 0, sof = 0, pv = 0, cmd_rdy = 1, dat_rdy = 1, sel = 0;
  logic [7:0] pd = 0;
  logic a_cv, a_dv, a_done, a_bank, a_busy, a_ovf, b_cv, b_dv, b_done, b_bank, b_busy, b_ovf;
  logic [27:0] a_ca, b_ca;
  logic [127:0] a_d, b_d;
  logic cv, dv, done, wrb, busy, ovf;
  logic [27:0] ca;
  logic [127:0] wd;
  int pass_n = 0, tot_n = 0, done_cnt = 0, cred = 0;
  logic [127:0] qd [$];
  logic [27:0] qc [$];
  bit hold_q = 0, bank_m = 0;
  logic [27:0] hold_a;
  always #5 clk = ~clk;
  ddr3_frame_writer #(.LINE_PIX(32), .FRAME_LINES(4), .BURST_WORDS(4)) u_dut (
    .clk(clk), .rst(rst), .write_start(ws && !sel), .pix_sof(sof), .pix_valid(pv), .pix_data(pd),
    .wr_cmd_valid(a_cv), .wr_cmd_ready(cmd_rdy), .wr_cmd_addr(a_ca),
    .wr_data_valid(a_dv), .wr_data_ready(dat_rdy), .wr_data(a_d),
    .write_frame_done(a_done), .wr_bank(a_bank), .busy(a_busy), .overflow(a_ovf)
  );
  ddr3_frame_writer #(.LINE_PIX(32), .FRAME_LINES(6), .BURST_WORDS(4)) u_ovf (
    .clk(clk), .rst(rst), .write_start(ws && sel), .pix_sof(sof), .pix_valid(pv), .pix_data(pd),
    .wr_cmd_valid(b_cv), .wr_cmd_ready(cmd_rdy), .wr_cmd_addr(b_ca),
    .wr_data_valid(b_dv), .wr_data_ready(dat_rdy), .wr_data(b_d),
    .write_frame_done(b_done), .wr_bank(b_bank), .busy(b_busy), .overflow(b_ovf)
  );
  assign cv = sel ? b_cv : a_cv;
  assign ca = sel ? b_ca : a_ca;
  assign dv = sel ? b_dv : a_dv;
  assign wd = sel ? b_d : a_d;
  assign done = sel ? b_done : a_done;
  assign wrb = sel ? b_bank : a_bank;
  assign busy = sel ? b_busy : a_busy;
  assign ovf = sel ? b_ovf : a_ovf;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      cred = 0;
      hold_q = 0;
    end else begin
      if (hold_q) begin
        chk("cmd_hold_valid", cv, 1);
        chk("cmd_hold_addr", ca, hold_a);
      end
      hold_q = cv && !cmd_rdy;
      hold_a = ca;
      if (cv && cmd_rdy) begin
        if (qc.size() == 0) chk("cmd_unexpected", cv, 0);
        else chk("cmd_addr", ca, qc.pop_front());
        cred += 4;
      end
      if (dv) chk("data_after_cmd", cred > 0, 1);
      if (dv && dat_rdy) begin
        if (qd.size() == 0) chk("data_unexpected", dv, 0);
        else chk("data_word", wd, qd.pop_front());
        cred--;
      end
      if (done) done_cnt++;
    end
  end
  task automatic push_exp(input int nkeep, input int ncmd);
    int base;
    logic [127:0] r;
    logic [7:0] v;
    base = bank_m ? B1 : 0;
    for (int c = 0; c < ncmd; c++) qc.push_back(28'(base + 4 * c));
    for (int w = 0; w < nkeep; w++) begin
      for (int p = 0; p < 16; p++) begin
        v = 8'(w * 16 + p);
        r[p*8 +: 8] = v;
      end
      qd.push_back(r);
    end
  endtask
  task automatic px(input logic [7:0] v, input logic s);
    @(posedge clk);
    #1 pv = 1;
    pd = v;
    sof = s;
  endtask
  task automatic send(input int pre, input int n, input int extra, input bit ws_sof, input bit ws_mid);
    @(posedge clk);
    #1 ws = 1;
    pv = ws_sof;
    sof = ws_sof;
    pd = 8'hAA;
    for (int i = 0; i < pre; i++) begin
      px(8'hAA, 0);
      ws = 0;
    end
    for (int i = 0; i < n; i++) begin
      px(8'(i), i == 0);
      ws = ws_mid && i == 50;
    end
    for (int i = 0; i < extra; i++) px(8'h55, i == 0);
    @(posedge clk);
    #1 pv = 0;
    sof = 0;
    ws = 0;
  endtask
  task automatic wait_done(input int d0, input string tag);
    for (int k = 0; k < 3000 && done_cnt == d0; k++) @(posedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_wr_bank"}, wrb, bank_m);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cmds_left"}, qc.size(), 0);
    chk({tag, "_words_left"}, qd.size(), 0);
    bank_m = ~bank_m;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_cmd_valid"}, cv, 0);
    chk({tag, "_cmd_addr"}, ca, 0);
    chk({tag, "_data_valid"}, dv, 0);
    chk({tag, "_data"}, wd, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wr_bank"}, wrb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overflow"}, ovf, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check_zero("reset");
    d0 = done_cnt;
    push_exp(8, 2);
    send(0, 128, 0, 0, 0);
    wait_done(d0, "f1");
    chk("f1_overflow", ovf, 0);
    d0 = done_cnt;
    push_exp(8, 2);
    send(0, 128, 0, 0, 0);
    wait_done(d0, "f2");
    d0 = done_cnt;
    push_exp(8, 2);
    fork
      send(0, 128, 0, 0, 0);
      begin
        cmd_rdy = 0;
        for (int k = 0; k < 500 && !cv; k++) @(negedge clk);
        repeat (10) @(posedge clk);
        #1 cmd_rdy = 1;
      end
    join
    wait_done(d0, "f3_cmdbp");
    d0 = done_cnt;
    push_exp(8, 2);
    fork
      send(0, 128, 0, 0, 0);
      begin
        repeat (400) begin
          @(posedge clk);
          #1 dat_rdy = 1'($urandom_range(0, 1));
        end
        dat_rdy = 1;
      end
    join
    wait_done(d0, "f4_datbp");
    d0 = done_cnt;
    push_exp(8, 2);
    send(40, 128, 20, 1, 1);
    wait_done(d0, "f5_arm");
    push_exp(4, 1);
    send(0, 80, 0, 0, 0);
    repeat (10) @(posedge clk);
    chk("midrst_cmds_seen", qc.size(), 0);
    chk("midrst_words_seen", qd.size(), 0);
    d0 = done_cnt;
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 check_zero("midrst");
    rst = 0;
    bank_m = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt, d0);
    d0 = done_cnt;
    push_exp(8, 2);
    send(0, 128, 0, 0, 0);
    wait_done(d0, "f7_after_rst");
    @(posedge clk);
    #1 sel = 1;
    bank_m = 0;
    dat_rdy = 0;
    d0 = done_cnt;
    push_exp(8, 2);
    send(0, 192, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("ovf_set", ovf, 1);
    chk("ovf_busy", busy, 1);
    chk("ovf_no_early_done", done_cnt, d0);
    @(posedge clk);
    #1 dat_rdy = 1;
    wait_done(d0, "ovf_frame");
    d0 = done_cnt;
    push_exp(12, 3);
    fork
      send(0, 192, 0, 0, 0);
      begin
        repeat (3) @(negedge clk);
        chk("ovf_cleared", ovf, 0);
      end
    join
    wait_done(d0, "ovf_next");
    chk("ovf_next_overflow", ovf, 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
